mac_accum_writeback: RTL and testbench



---
 rtl/mac_accum_writeback.sv | 180 ++++++++++++++++++
 tb/tb_mac_accum_writeback.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_writeback.sv
// Accumulates K consecutive products into each C(M x N) element and writes it to result memory.
// Optional build macro MAC_ACCUM_ELEM_COUNT_EN adds the elem_count output (writes since last start).
//
// state | meaning
// IDLE  | waiting for start; any product_valid here is a protocol error
// ACCUM | consuming products, one result write per K accepted products
// DONE  | one-cycle completion pulse (coincides with the final write), then IDLE
module mac_accum_writeback #(
   parameter int M                        = 2,
   parameter int K                        = 2,
   parameter int N                        = 2,
   parameter int DATA_WIDTH_INIT_MATRIX   = 32,
   parameter int DATA_WIDTH_RESULT_MATRIX = DATA_WIDTH_INIT_MATRIX*2 + $clog2(K)
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic                                start,
   input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_in,
   input  logic                                product_valid,
   output logic [$clog2(M)-1:0]                c_row_addr,
   output logic [$clog2(N)-1:0]                c_col_addr,
   output logic [DATA_WIDTH_RESULT_MATRIX-1:0] c_wr_data,
   output logic                                c_we,
   output logic                                busy,
   output logic                                done,
`ifdef MAC_ACCUM_ELEM_COUNT_EN
   output logic [$clog2(M*N+1)-1:0]            elem_count,
`endif
   output logic                                err_protocol
);

   localparam int RW  = DATA_WIDTH_RESULT_MATRIX;
   localparam int KW  = $clog2(K);
   localparam int RAW = $clog2(M);
   localparam int CAW = $clog2(N);

   localparam logic [KW-1:0]  K_LAST   = KW'(K-1);
   localparam logic [RAW-1:0] ROW_LAST = RAW'(M-1);
   localparam logic [CAW-1:0] COL_LAST = CAW'(N-1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_start_acc;

   logic [RW-1:0]    r_acc;
   logic [KW-1:0]    r_k_cnt;
   logic [RAW-1:0]   r_row_cnt;
   logic [CAW-1:0]   r_col_cnt;

   logic [RAW-1:0]   r_c_row_addr;
   logic [CAW-1:0]   r_c_col_addr;
   logic [RW-1:0]    r_c_wr_data;
   logic             r_c_we;
   logic             r_err_protocol;

   logic             w_take;
   logic             w_k_last;
   logic             w_elem_done;
   logic             w_last_elem;
   logic [RW-1:0]    w_sum;

   assign w_take      = (r_state == ACCUM) && product_valid;
   assign w_k_last    = (r_k_cnt == K_LAST);
   assign w_elem_done = w_take && w_k_last;
   assign w_last_elem = w_elem_done && (r_row_cnt == ROW_LAST) && (r_col_cnt == COL_LAST);
   assign w_sum       = r_acc + RW'(product_in);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = ACCUM;
               w_start_acc = 1'b1;
            end
         end
         ACCUM: begin
            if (w_last_elem) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Element accumulation and write-back; write fields hold between completions.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_acc        <= '0;
         r_k_cnt      <= '0;
         r_row_cnt    <= '0;
         r_col_cnt    <= '0;
         r_c_row_addr <= '0;
         r_c_col_addr <= '0;
         r_c_wr_data  <= '0;
         r_c_we       <= 1'b0;
      end else begin
         r_c_we <= w_elem_done;
         if (w_start_acc) begin
            r_acc     <= '0;
            r_k_cnt   <= '0;
            r_row_cnt <= '0;
            r_col_cnt <= '0;
         end else if (w_take) begin
            if (w_k_last) begin
               r_c_wr_data  <= w_sum;
               r_c_row_addr <= r_row_cnt;
               r_c_col_addr <= r_col_cnt;
               r_acc        <= '0;
               r_k_cnt      <= '0;
               if (r_col_cnt == COL_LAST) begin
                  r_col_cnt <= '0;
                  r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + 1'b1;
               end else begin
                  r_col_cnt <= r_col_cnt + 1'b1;
               end
            end else begin
               r_acc   <= w_sum;
               r_k_cnt <= r_k_cnt + 1'b1;
            end
         end
      end
   end

   // A product outside ACCUM is flagged even in the cycle that start clears the flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_err_protocol <= 1'b0;
      end else if (product_valid && (r_state != ACCUM)) begin
         r_err_protocol <= 1'b1;
      end else if (w_start_acc) begin
         r_err_protocol <= 1'b0;
      end
   end

`ifdef MAC_ACCUM_ELEM_COUNT_EN
   logic [$clog2(M*N+1)-1:0] r_elem_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_elem_count <= '0;
      end else if (w_start_acc) begin
         r_elem_count <= '0;
      end else if (w_elem_done) begin
         r_elem_count <= r_elem_count + 1'b1;
      end
   end

   assign elem_count = r_elem_count;
`endif

   assign c_row_addr   = r_c_row_addr;
   assign c_col_addr   = r_c_col_addr;
   assign c_wr_data    = r_c_wr_data;
   assign c_we         = r_c_we;
   assign busy         = (r_state == ACCUM);
   assign done         = (r_state == DONE);
   assign err_protocol = r_err_protocol;

endmodule

// File: tb/tb_mac_accum_writeback.sv
// Bench for mac_accum_writeback at M=K=N=2, 8-bit operands: a directed cycle table plus
// randomized streams checked against an element-level sum model.
module tb_mac_accum_writeback;

   localparam int M   = 2;
   localparam int K   = 2;
   localparam int N   = 2;
   localparam int W   = 8;
   localparam int RW  = 2*W + $clog2(K);
   localparam int TOT = M*N*K;

   logic                      clk;
   logic                      resetn;
   logic                      start;
   logic [2*W-1:0]            product_in;
   logic                      product_valid;
   logic [$clog2(M)-1:0]      c_row_addr;
   logic [$clog2(N)-1:0]      c_col_addr;
   logic [RW-1:0]             c_wr_data;
   logic                      c_we;
   logic                      busy;
   logic                      done;
   logic                      err_protocol;
`ifdef MAC_ACCUM_ELEM_COUNT_EN
   logic [$clog2(M*N+1)-1:0]  elem_count;
`endif

   mac_accum_writeback #(
      .M(M), .K(K), .N(N),
      .DATA_WIDTH_INIT_MATRIX(W),
      .DATA_WIDTH_RESULT_MATRIX(RW)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .start(start),
      .product_in(product_in),
      .product_valid(product_valid),
      .c_row_addr(c_row_addr),
      .c_col_addr(c_col_addr),
      .c_wr_data(c_wr_data),
      .c_we(c_we),
      .busy(busy),
      .done(done),
`ifdef MAC_ACCUM_ELEM_COUNT_EN
      .elem_count(elem_count),
`endif
      .err_protocol(err_protocol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model state: products of the current matrix and what the write port should be holding.
   logic [2*W-1:0] cur_prod [TOT];
   longint         last_data;
   int             last_row;
   int             last_col;
   int             n_writes;

   typedef struct {
      logic        pv;
      logic [15:0] prod;
      logic        we;
      int          data;
      int          row;
      int          col;
      logic        dn;
      logic        bsy;
      int          cnt;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_cnt(input int exp);
`ifdef MAC_ACCUM_ELEM_COUNT_EN
      chk("elem_count", 32'(elem_count), 32'(exp));
`else
      if (exp < 0) $display("negative element count %0d", exp);
`endif
   endtask

   task automatic chk_port(input logic exp_we, input logic exp_done, input logic exp_busy,
                           input logic exp_err);
      chk("c_we", 32'(c_we), 32'(exp_we));
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("err_protocol", 32'(err_protocol), 32'(exp_err));
      chk("c_wr_data", 32'(c_wr_data), 32'(last_data));
      chk("c_row_addr", 32'(c_row_addr), 32'(last_row));
      chk("c_col_addr", 32'(c_col_addr), 32'(last_col));
      chk_cnt(n_writes);
   endtask

   task automatic do_start(input logic with_pv);
      start         = 1'b1;
      product_valid = with_pv;
      product_in    = 16'($urandom);
      @(posedge clk); #1;
      start         = 1'b0;
      product_valid = 1'b0;
      n_writes      = 0;
      chk_port(1'b0, 1'b0, 1'b1, with_pv);
   endtask

   // Feeds n_prod products of cur_prod with 0..gap_max idle cycles before each one.
   // Element e completes on product (e+1)*K and must be written on the following cycle.
   task automatic feed(input int gap_max, input int inj_idx, input logic exp_err,
                       input int n_prod, input logic tail_pv);
      int     gaps;
      int     e;
      longint sum;
      for (int i = 0; i < n_prod; i++) begin
         gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         for (int g = 0; g < gaps; g++) begin
            product_valid = 1'b0;
            product_in    = 16'($urandom);
            @(posedge clk); #1;
            chk_port(1'b0, 1'b0, 1'b1, exp_err);
         end
         product_valid = 1'b1;
         product_in    = cur_prod[i];
         start         = (i == inj_idx);
         @(posedge clk); #1;
         product_valid = 1'b0;
         start         = 1'b0;
         if ((i + 1) % K == 0) begin
            e   = (i + 1) / K - 1;
            sum = 0;
            for (int j = 0; j < K; j++) sum += longint'(cur_prod[e*K + j]);
            last_data = sum;
            last_row  = e / N;
            last_col  = e % N;
            n_writes++;
            chk_port(1'b1, e == M*N-1, e != M*N-1, exp_err);
         end else begin
            chk_port(1'b0, 1'b0, 1'b1, exp_err);
         end
      end
      if (n_prod == TOT) begin
         product_valid = tail_pv;
         product_in    = 16'($urandom);
         @(posedge clk); #1;
         product_valid = 1'b0;
         chk_port(1'b0, 1'b0, 1'b0, exp_err | tail_pv);
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 16'd5,  1'b0, 0,  0, 0, 1'b0, 1'b1, 0};
      tbl[1] = '{1'b1, 16'd14, 1'b1, 19, 0, 0, 1'b0, 1'b1, 1};
      tbl[2] = '{1'b1, 16'd6,  1'b0, 19, 0, 0, 1'b0, 1'b1, 1};
      tbl[3] = '{1'b1, 16'd16, 1'b1, 22, 0, 1, 1'b0, 1'b1, 2};
      tbl[4] = '{1'b1, 16'd15, 1'b0, 22, 0, 1, 1'b0, 1'b1, 2};
      tbl[5] = '{1'b1, 16'd28, 1'b1, 43, 1, 0, 1'b0, 1'b1, 3};
      tbl[6] = '{1'b1, 16'd18, 1'b0, 43, 1, 0, 1'b0, 1'b1, 3};
      tbl[7] = '{1'b1, 16'd32, 1'b1, 50, 1, 1, 1'b1, 1'b0, 4};
      tbl[8] = '{1'b0, 16'd0,  1'b0, 50, 1, 1, 1'b0, 1'b0, 4};

      resetn        = 1'b0;
      start         = 1'b0;
      product_valid = 1'b0;
      product_in    = '0;
      last_data     = 0;
      last_row      = 0;
      last_col      = 0;
      n_writes      = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_port(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;

      // Directed basic matrix, one product per cycle.
      do_start(1'b0);
      for (int i = 0; i < 9; i++) begin
         product_valid = tbl[i].pv;
         product_in    = tbl[i].prod;
         @(posedge clk); #1;
         product_valid = 1'b0;
         chk("tbl_we",   32'(c_we), 32'(tbl[i].we));
         chk("tbl_data", 32'(c_wr_data), 32'(tbl[i].data));
         chk("tbl_row",  32'(c_row_addr), 32'(tbl[i].row));
         chk("tbl_col",  32'(c_col_addr), 32'(tbl[i].col));
         chk("tbl_done", 32'(done), 32'(tbl[i].dn));
         chk("tbl_busy", 32'(busy), 32'(tbl[i].bsy));
         chk_cnt(tbl[i].cnt);
         n_writes = tbl[i].cnt;
      end
      last_data = 50;
      last_row  = 1;
      last_col  = 1;

      // Same stream with random stalls, then fully random products.
      for (int i = 0; i < TOT; i++) cur_prod[i] = tbl[i].prod;
      do_start(1'b0);
      feed(3, -1, 1'b0, TOT, 1'b0);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < TOT; i++) cur_prod[i] = 16'($urandom_range(0, 65025));
         do_start(1'b0);
         feed(3, -1, 1'b0, TOT, 1'b0);
      end

      // Maximum products: 2 * 65025 needs the 17th bit.
      for (int i = 0; i < TOT; i++) cur_prod[i] = 16'd65025;
      do_start(1'b0);
      feed(0, -1, 1'b0, TOT, 1'b0);
      chk("wide_sum", 32'(c_wr_data), 32'd130050);

      // Product while IDLE: flagged, discarded, sticky until the next start.
      product_valid = 1'b1;
      product_in    = 16'd77;
      @(posedge clk); #1;
      product_valid = 1'b0;
      chk_port(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk_port(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < TOT; i++) cur_prod[i] = 16'($urandom_range(0, 65025));
      do_start(1'b0);
      // start mid-ACCUM is ignored; product during DONE sets the flag.
      feed(1, 3, 1'b0, TOT, 1'b1);
      // start and product together in IDLE: start taken, flag set wins.
      do_start(1'b1);
      feed(2, -1, 1'b1, TOT, 1'b0);
      do_start(1'b0);
      feed(0, -1, 1'b0, TOT, 1'b0);

      // Reset mid-operation.
      for (int i = 0; i < TOT; i++) cur_prod[i] = 16'($urandom_range(1, 65025));
      do_start(1'b0);
      feed(0, -1, 1'b0, 3, 1'b0);
      resetn = 1'b0;
      #1;
      last_data = 0;
      last_row  = 0;
      last_col  = 0;
      n_writes  = 0;
      chk_port(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      chk_port(1'b0, 1'b0, 1'b0, 1'b0);
      do_start(1'b0);
      feed(2, -1, 1'b0, TOT, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
